// File: rtl/bk_bus_pkg.sv
// Shared BK peripheral-bus definitions: master sequencing states, byte-lane codes, .BIN header layout.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package bk_bus_pkg;

  // Bus master sequencing, shared with the CPU-side bus mux.
  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_REQ,
    BUS_SYNC,
    BUS_STB,
    BUS_REL
  } bus_state_t;

  // Download loader control states.
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_HDR,
    LD_DATA,
    LD_BUS,
    LD_FIN,
    LD_ERR
  } ld_state_t;

  // wtbt byte-lane codes {hi,lo}.
  localparam logic [1:0] WTBT_LO   = 2'b01;
  localparam logic [1:0] WTBT_HI   = 2'b10;
  localparam logic [1:0] WTBT_WORD = 2'b11;

  // Byte offsets inside the 4-byte .BIN header (both words little-endian).
  localparam logic [1:0] HDR_ADDR_LO = 2'd0;
  localparam logic [1:0] HDR_ADDR_HI = 2'd1;
  localparam logic [1:0] HDR_LEN_LO  = 2'd2;
  localparam logic [1:0] HDR_LEN_HI  = 2'd3;

  // Lane select for a byte at an odd/even address.
  function automatic logic [1:0] lane_mask(input logic odd);
    return odd ? WTBT_HI : WTBT_LO;
  endfunction

  // Byte positioned in its lane, other lane zero.
  function automatic logic [15:0] lane_place(input logic odd, input logic [7:0] b);
    return odd ? {b, 8'h00} : {8'h00, b};
  endfunction

endpackage

// File: rtl/bk_bus_master_if.sv
// Generic BK bus write master: request bus, run one sync/stb write, release; abort on ack timeout.
// Latency: minimum 4 cycles from REQ-with-grant to REL exit (REQ, SYNC, STB with ack, REL).
// Backpressure: holds in REQ until dma_gnt and in STB until bus_ack or TIMEOUT cycles elapse.
module bk_bus_master_if
  import bk_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  input  logic [1:0]  wtbt,
  output logic        ready,
  output logic        fault,
  output logic        dma_req,
  input  logic        dma_gnt,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_dout,
  output logic        bus_sync,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [1:0]  bus_wtbt,
  input  logic        bus_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  bus_state_t    state;
  bus_state_t    state_nxt;
  logic [CW-1:0] stb_cnt;
  logic [15:0]   lat_addr;
  logic [15:0]   lat_dat;
  logic [1:0]    lat_wtbt;
  logic          timeout_hit;

  // Last STB cycle allowed without an ack.
  assign timeout_hit = (state == BUS_STB) && !bus_ack && (stb_cnt == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= BUS_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: one write per start, timeout falls straight back to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      BUS_IDLE: if (start) state_nxt = BUS_REQ;
      BUS_REQ:  if (dma_gnt) state_nxt = BUS_SYNC;
      BUS_SYNC: state_nxt = BUS_STB;
      BUS_STB: begin
        if (bus_ack)          state_nxt = BUS_REL;
        else if (timeout_hit) state_nxt = BUS_IDLE;
      end
      BUS_REL:  state_nxt = BUS_IDLE;
      default:  state_nxt = BUS_IDLE;
    endcase
  end

  // Capture the write on start so the caller may reuse its buffer; count STB cycles.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      stb_cnt  <= '0;
      lat_addr <= '0;
      lat_dat  <= '0;
      lat_wtbt <= '0;
    end else begin
      stb_cnt <= (state == BUS_STB) ? stb_cnt + CW'(1) : '0;
      if (state == BUS_IDLE && start) begin
        lat_addr <= {addr[15:1], 1'b0};
        lat_dat  <= data;
        lat_wtbt <= wtbt;
      end
    end
  end

  // Bus outputs decoded from state; address/data only driven while sync is up.
  always_comb begin
    dma_req  = 1'b0;
    bus_sync = 1'b0;
    bus_stb  = 1'b0;
    bus_we   = 1'b0;
    bus_addr = '0;
    bus_dout = '0;
    bus_wtbt = '0;
    ready    = 1'b0;
    fault    = timeout_hit;
    case (state)
      BUS_REQ:  dma_req = 1'b1;
      BUS_SYNC, BUS_STB: begin
        dma_req  = 1'b1;
        bus_sync = 1'b1;
        bus_stb  = (state == BUS_STB);
        bus_we   = 1'b1;
        bus_addr = lat_addr;
        bus_dout = lat_dat;
        bus_wtbt = lat_wtbt;
      end
      BUS_REL: begin
        // stb already low, sync drops on exit; bus is handed back to the CPU here.
        bus_sync = 1'b1;
        bus_we   = 1'b1;
        bus_addr = lat_addr;
        bus_dout = lat_dat;
        bus_wtbt = lat_wtbt;
        ready    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bin_bus_loader.sv
// Turns a BK .BIN ioctl download (header + bytes) into aligned word/byte writes on the CPU bus.
// Latency: one bus write per filled word, at least 4 cycles each once granted; done pulses after the last.
// Backpressure: ioctl_wait high while a word is on the bus and in FIN; bytes swallowed freely in ERR.
module bin_bus_loader
  import bk_bus_pkg::*;
#(
  parameter int          TIMEOUT = 255,
  parameter bit          HEADER  = 1'b1,
  parameter logic [15:0] BASE    = 16'o1000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        dma_req,
  input  logic        dma_gnt,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_dout,
  output logic        bus_sync,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [1:0]  bus_wtbt,
  input  logic        bus_ack,
  output logic        busy,
  output logic        done,
  output logic        error
);

  ld_state_t   state;
  ld_state_t   state_nxt;
  logic        dl_prev;
  logic [1:0]  hdr_cnt;
  logic [15:0] addr;
  logic [15:0] len;
  logic [15:0] word_addr;
  logic [15:0] word_dat;
  logic [1:0]  word_wtbt;
  logic        error_q;
  logic        dl_rise;
  logic        last_byte;
  logic        mst_start;
  logic        mst_ready;
  logic        mst_fault;

  assign dl_rise   = ioctl_download && !dl_prev;
  // Without a header the length is open-ended: only the end of download stops the load.
  assign last_byte = HEADER && (len == 16'd1);
  assign mst_start = (state == LD_BUS);
  assign error     = error_q;

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= LD_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: header parse, word assembly, bus hand-off, completion and fault paths.
  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE: if (dl_rise) state_nxt = HEADER ? LD_HDR : LD_DATA;
      LD_HDR: begin
        if (ioctl_wr) begin
          if (hdr_cnt == HDR_LEN_HI)
            state_nxt = ({ioctl_dout, len[7:0]} == 16'd0) ? LD_FIN : LD_DATA;
        end else if (!ioctl_download) begin
          state_nxt = LD_ERR;
        end
      end
      LD_DATA: begin
        if (ioctl_wr) begin
          if (addr[0] || last_byte) state_nxt = LD_BUS;
        end else if (!ioctl_download) begin
          // Flush a half word first; the shortfall is flagged on the return trip.
          if (word_wtbt != 2'b00)       state_nxt = LD_BUS;
          else if (HEADER && len != '0) state_nxt = LD_ERR;
          else                          state_nxt = LD_FIN;
        end
      end
      LD_BUS: begin
        if (mst_fault)      state_nxt = LD_ERR;
        else if (mst_ready) state_nxt = (HEADER && len == '0) ? LD_FIN : LD_DATA;
      end
      LD_FIN:  state_nxt = LD_IDLE;
      LD_ERR:  if (!ioctl_download) state_nxt = LD_IDLE;
      default: state_nxt = LD_IDLE;
    endcase
  end

  // Header capture, byte-lane assembly, address/length tracking and the sticky error flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_prev   <= 1'b0;
      hdr_cnt   <= '0;
      addr      <= '0;
      len       <= '0;
      word_addr <= '0;
      word_dat  <= '0;
      word_wtbt <= '0;
      error_q   <= 1'b0;
    end else begin
      dl_prev <= ioctl_download;
      if (state_nxt == LD_ERR) error_q <= 1'b1;
      case (state)
        LD_IDLE: begin
          if (dl_rise) begin
            error_q   <= 1'b0;
            hdr_cnt   <= '0;
            addr      <= BASE;
            len       <= '0;
            word_dat  <= '0;
            word_wtbt <= '0;
          end
        end
        LD_HDR: begin
          if (ioctl_wr) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
              HDR_ADDR_LO: addr[7:0]  <= ioctl_dout;
              HDR_ADDR_HI: addr[15:8] <= ioctl_dout;
              HDR_LEN_LO:  len[7:0]   <= ioctl_dout;
              default:     len[15:8]  <= ioctl_dout;
            endcase
          end
        end
        LD_DATA: begin
          if (ioctl_wr) begin
            word_dat  <= word_dat | lane_place(addr[0], ioctl_dout);
            word_wtbt <= word_wtbt | lane_mask(addr[0]);
            word_addr <= {addr[15:1], 1'b0};
            addr      <= addr + 16'd1;  // wraps 'o177777 -> 0
            if (HEADER) len <= len - 16'd1;
          end
        end
        LD_BUS: begin
          if (mst_ready || mst_fault) begin
            word_dat  <= '0;
            word_wtbt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    ioctl_wait = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      LD_HDR, LD_DATA: busy = 1'b1;
      LD_BUS: begin
        busy       = 1'b1;
        ioctl_wait = 1'b1;
      end
      LD_FIN: begin
        done       = 1'b1;
        ioctl_wait = 1'b1;
      end
      default: ;
    endcase
  end

  bk_bus_master_if #(
    .TIMEOUT(TIMEOUT)
  ) u_master (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (mst_start),
    .addr     (word_addr),
    .data     (word_dat),
    .wtbt     (word_wtbt),
    .ready    (mst_ready),
    .fault    (mst_fault),
    .dma_req  (dma_req),
    .dma_gnt  (dma_gnt),
    .bus_addr (bus_addr),
    .bus_dout (bus_dout),
    .bus_sync (bus_sync),
    .bus_stb  (bus_stb),
    .bus_we   (bus_we),
    .bus_wtbt (bus_wtbt),
    .bus_ack  (bus_ack)
  );

endmodule

// File: tb/tb_bin_bus_loader.sv
// Bench for bin_bus_loader: directed .BIN loads plus randomized loads checked against a byte-grouping model.
// Latency: n/a.
// Backpressure: bench honours ioctl_wait; responder delays grant/ack per test.
module tb_bin_bus_loader;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] dat;
    logic [1:0]  wtbt;
  } wr_t;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        dma_req;
  logic        dma_gnt;
  logic [15:0] bus_addr;
  logic [15:0] bus_dout;
  logic        bus_sync;
  logic        bus_stb;
  logic        bus_we;
  logic [1:0]  bus_wtbt;
  logic        bus_ack;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  int gnt_delay = 0;
  int ack_delay = 0;
  bit ack_never = 1'b0;
  int gnt_cnt   = 0;
  int stb_cnt   = 0;
  int max_stb   = 0;
  int done_cnt  = 0;
  int viol      = 0;

  wr_t        cap_q[$];
  wr_t        exp_q[$];
  logic [7:0] dbytes [0:15];

  bin_bus_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dma_req        (dma_req),
    .dma_gnt        (dma_gnt),
    .bus_addr       (bus_addr),
    .bus_dout       (bus_dout),
    .bus_sync       (bus_sync),
    .bus_stb        (bus_stb),
    .bus_we         (bus_we),
    .bus_wtbt       (bus_wtbt),
    .bus_ack        (bus_ack),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CPU grant + responder ack model, write capture and protocol watch, all on the falling edge.
  initial begin
    dma_gnt = 1'b0;
    bus_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (dma_req) begin
        gnt_cnt++;
        dma_gnt = (gnt_cnt > gnt_delay);
      end else begin
        gnt_cnt = 0;
        dma_gnt = 1'b0;
      end
      if (bus_stb) begin
        stb_cnt++;
        bus_ack = !ack_never && (stb_cnt > ack_delay);
        if (stb_cnt > max_stb) max_stb = stb_cnt;
      end else begin
        stb_cnt = 0;
        bus_ack = 1'b0;
      end
      if (bus_stb && bus_ack) cap_q.push_back('{addr: bus_addr, dat: bus_dout, wtbt: bus_wtbt});
      if (done) done_cnt++;
      if ((dma_req && !dma_gnt && (bus_sync || !ioctl_wait)) ||
          (bus_stb && (!bus_sync || !bus_we || !dma_gnt)))
        viol++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (ioctl_wait && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("wait_clr", ioctl_wait, 0);
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
    if ($urandom_range(0, 3) == 0) @(negedge clk_sys);
  endtask

  // One complete download: header (a, l), ns data bytes from dbytes, then download ends.
  task automatic run_load(input logic [15:0] a, input logic [15:0] l, input int ns, input bit tmo);
    int          n;
    int          k;
    logic [15:0] ba;
    logic [15:0] wa;
    wr_t         e;
    cap_q.delete();
    exp_q.delete();
    done_cnt = 0;
    max_stb  = 0;
    viol     = 0;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(l[7:0]);
    send_byte(l[15:8]);
    for (int i = 0; i < ns; i++) send_byte(dbytes[i]);
    ioctl_download = 1'b0;
    n = 0;
    while ((busy || ioctl_wait) && n < 5000) begin
      @(negedge clk_sys);
      n++;
    end
    repeat (3) @(negedge clk_sys);
    check_eq("settled", {busy, ioctl_wait, dma_req, bus_sync, bus_stb}, 0);
    check_eq("viol", viol, 0);

    if (tmo) begin
      check_eq("tmo_nwr", cap_q.size(), 0);
      check_eq("tmo_stb_cycles", max_stb, 255);
      check_eq("tmo_error", error, 1);
      check_eq("tmo_done", done_cnt, 0);
    end else begin
      // Reference: the first min(ns,l) bytes, consecutive bytes sharing a word merged into one write.
      k = (ns < int'(l)) ? ns : int'(l);
      for (int i = 0; i < k; i++) begin
        ba = a + 16'(i);
        wa = {ba[15:1], 1'b0};
        if (exp_q.size() == 0 || exp_q[$].addr != wa) begin
          e = '{addr: wa, dat: 16'h0000, wtbt: 2'b00};
          exp_q.push_back(e);
        end
        e = exp_q[$];
        if (ba[0]) begin
          e.dat[15:8] = dbytes[i];
          e.wtbt[1]   = 1'b1;
        end else begin
          e.dat[7:0]  = dbytes[i];
          e.wtbt[0]   = 1'b1;
        end
        exp_q[$] = e;
      end
      check_eq("nwr", cap_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
        check_eq($sformatf("wr%0d", i), cap_q[i], exp_q[i]);
      check_eq("done", done_cnt, (ns >= int'(l)) ? 1 : 0);
      check_eq("error", error, (ns < int'(l)) ? 1 : 0);
    end
  endtask

  initial begin
    int   n;
    int   ns;
    logic [15:0] ra;
    logic [15:0] rl;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_dout     = 8'h00;
    repeat (3) @(negedge clk_sys);
    check_eq("reset_outputs",
             {ioctl_wait, dma_req, bus_addr, bus_dout, bus_sync, bus_stb, bus_we, bus_wtbt, busy, done, error}, 0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Header 00 02 04 00, two full words.
    dbytes[0] = 8'h11; dbytes[1] = 8'h22; dbytes[2] = 8'h33; dbytes[3] = 8'h44;
    run_load(16'h0200, 16'd4, 4, 1'b0);
    if (cap_q.size() >= 2) begin
      check_eq("t1_w0", cap_q[0], {16'h0200, 16'h2211, 2'b11});
      check_eq("t1_w1", cap_q[1], {16'h0202, 16'h4433, 2'b11});
    end

    // Odd start address: high-lane byte, then a full word.
    dbytes[0] = 8'hAA; dbytes[1] = 8'hBB; dbytes[2] = 8'hCC;
    run_load(16'o1001, 16'd3, 3, 1'b0);
    if (cap_q.size() >= 2) begin
      check_eq("t2_w0", cap_q[0], {16'h0200, 16'hAA00, 2'b10});
      check_eq("t2_w1", cap_q[1], {16'h0202, 16'hCCBB, 2'b11});
    end

    // Responder never acks.
    ack_never = 1'b1;
    run_load(16'h0300, 16'd4, 4, 1'b1);
    ack_never = 1'b0;

    // Slow grant.
    gnt_delay = 10;
    dbytes[0] = 8'h5A; dbytes[1] = 8'hA5;
    run_load(16'h0400, 16'd2, 2, 1'b0);
    gnt_delay = 0;

    // Short download: len 6, only 3 bytes.
    dbytes[0] = 8'h01; dbytes[1] = 8'h02; dbytes[2] = 8'h03;
    run_load(16'h0200, 16'd6, 3, 1'b0);

    // Zero length: trailing bytes ignored.
    run_load(16'h0500, 16'd0, 2, 1'b0);

    // Reset while STB is up.
    ack_delay = 50;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h77); send_byte(8'h88);
    n = 0;
    while (!bus_stb && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("rst_stb_seen", bus_stb, 1);
    reset          = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check_eq("rst_mid_outputs",
             {ioctl_wait, dma_req, bus_addr, bus_dout, bus_sync, bus_stb, bus_we, bus_wtbt, busy, done, error}, 0);
    reset     = 1'b0;
    ack_delay = 0;
    @(negedge clk_sys);
    dbytes[0] = 8'h9C; dbytes[1] = 8'hC9; dbytes[2] = 8'h3E;
    run_load(16'h0600, 16'd3, 3, 1'b0);

    // Randomized loads, including address wrap and short downloads.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) dbytes[i] = 8'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      rl = 16'($urandom_range(0, 9));
      if (rl > 0 && $urandom_range(0, 3) == 0) ns = $urandom_range(0, int'(rl) - 1);
      else                                     ns = int'(rl) + $urandom_range(0, 2);
      gnt_delay = $urandom_range(0, 3);
      ack_delay = $urandom_range(0, 3);
      run_load(ra, rl, ns, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
